mmu_pagemap: RTL and testbench
==============================

// Module: mmu_pagemap
// PURPOSE
//  Parametrised successor to the single-page selector: maps NUM_WIN 8 KB CPU windows onto a
//  2^(PAGE_BITS+13)-byte external space, each through its own page register. Adds per-window
//  write-protect, a two-byte key-sequence unlock for lock/control registers, and a violation flag/irq.
//  Sits on the $E6E0 I/O slot; translated address drives external RAM chip-select logic.
// PARAMETERS
//  NUM_WIN     4     number of windows (1..4); window i covers CPU A[15:13] == WIN_BASE+i
//  PAGE_BITS   8     page register width; ext address = {page, A[12:0]}
//  WIN_BASE    3'd4  first window slot ($8000); WIN_BASE+NUM_WIN-1 must be <= 7
//  KEY_TIMEOUT 16    clk cycles allowed between key bytes and before unlock expires
// PORTS
//  clk       in   1            system clock (sys_clk)
//  rst       in   1            synchronous reset, active-high
//  AD        in   4            register select
//  DI        in   8            CPU write data
//  DO        out  8            register read data
//  rw        in   1            1 = read, 0 = write
//  cs        in   1            register chip select (decode && vma)
//  cpu_addr  in   16           CPU address bus for translation
//  cpu_rw    in   1            CPU rw for write-protect check
//  map_hit   out  1            cpu_addr falls in an enabled window
//  map_addr  out  PAGE_BITS+13 translated external address
//  map_wp    out  1            hit window is write-protected and cpu_rw=0 (block ext write)
//  bram_disable out 1          control bit 0
//  brom_disable out 1          control bit 1
//  irq       out  1            violation flag && irq enable
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Register write = cs && !rw at posedge clk; effect visible
//    next cycle. Reads combinational: DO = selected reg while cs, else 8'h00. Unmapped AD read 8'h00.
//  - Map: 0..NUM_WIN-1 PAGE[i] (upper bits read 0 if PAGE_BITS<8; PAGE_BITS>8 upper bits via $4+i);
//    $8 CTRL {5'b0, map_en, brom_dis, bram_dis}; $9 WPMASK[NUM_WIN-1:0]; $A LOCKMASK; $B KEY (w);
//    $C STATUS {irq_en, 4'b0, viol, key_state[1:0]}; write $C: bit7 sets irq_en, bit2=1 clears viol.
//  - Reset: PAGE[i]=i, CTRL=0, WPMASK=0, LOCKMASK=0, viol=0, irq_en=0, FSM=IDLE; outputs map_hit=0,
//    map_wp=0, map_addr=cpu_addr-derived with page 0, bram/brom_disable=0, irq=0, DO=0.
//  - PAGE[i] write ignored when LOCKMASK[i]=1 and FSM!=UNLOCKED; ignored write sets viol.
//  - CTRL, WPMASK, LOCKMASK writes: accepted only in UNLOCKED, except LOCKMASK bits may always be SET
//    (OR-in); any other rejected write sets viol.
//  - Key FSM: IDLE -(write $B = A5)-> KEY1, timer=0. KEY1 -(write $B = 5A, timer<KEY_TIMEOUT)->
//    UNLOCKED, timer=0. KEY1 wrong byte -> IDLE + viol. KEY1 timer==KEY_TIMEOUT -> IDLE (no viol).
//    UNLOCKED: first accepted write to CTRL/WPMASK/LOCKMASK/PAGE of locked window consumes it -> IDLE;
//    timer==KEY_TIMEOUT -> IDLE. Write $B in UNLOCKED -> IDLE (relock). Timer saturates; counts clk.
//    key_state encoding IDLE=0, KEY1=1, UNLOCKED=2.
//  - Translation combinational from registers: map_hit = map_en && A[15:13] in window range;
//    map_addr = {PAGE[A[15:13]-WIN_BASE], A[12:0]} on hit, else {0, cpu_addr}.
//    map_wp = map_hit && WPMASK[win] && !cpu_rw; each occurrence sets viol (sticky).
//  - viol set and clear in same cycle: set wins. irq = viol && irq_en, level.
//  - rst mid-sequence returns FSM to IDLE and all registers to reset values.
// TESTING
//  - Reset, read $0..$3 -> 00,01,02,03; $8 -> 00; map_en=0 so cpu_addr $8123 -> map_hit=0.
//  - Unlock (A5,5A), write $8=04; write $2=3C; cpu_addr $C010 -> map_hit=1, map_addr=21'h078010.
//  - Write $A=01 (lock win0), write $0=55 -> PAGE0 stays 00, STATUS viol=1; irq_en set -> irq=1.
//  - Write $B=A5, wait KEY_TIMEOUT cycles, write $B=5A -> state IDLE, CTRL write rejected, viol=1.
//  - Unlock, WPMASK=02, CPU write at $A000 -> map_wp=1, viol=1; CPU read at $A000 -> map_wp=0.
//  - Reset asserted while UNLOCKED -> key_state=0, LOCKMASK=0, PAGE[i]=i next cycle.

Source files
------------

// File: rtl/mmu_pagemap.sv
// mmu_pagemap: maps NUM_WIN 8 KB CPU windows onto a 2^(PAGE_BITS+13)-byte external
// space through per-window page registers. It adds per-window write-protect, a two-byte
// key sequence ($A5 then $5A to $B) that unlocks locked registers for one write, and a
// sticky violation flag that can raise a level irq.
//
// Register handshake: a register write happens when cs && !rw at a rising clk edge, and
// the new value is visible from the next cycle. Reads are combinational and there is no
// wait state: DO shows the selected register while cs is high, and 8'h00 otherwise.
// The current key state can be read back in STATUS[1:0] (IDLE=0, KEY1=1, UNLOCKED=2).
// Page registers wider than 16 bits are not supported by the byte access helpers.
module mmu_pagemap #(
  parameter int         NUM_WIN     = 4,
  parameter int         PAGE_BITS   = 8,
  parameter logic [2:0] WIN_BASE    = 3'd4,
  parameter int         KEY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           AD,
  input  logic [7:0]           DI,
  output logic [7:0]           DO,
  input  logic                 rw,
  input  logic                 cs,
  input  logic [15:0]          cpu_addr,
  input  logic                 cpu_rw,
  output logic                 map_hit,
  output logic [PAGE_BITS+12:0] map_addr,
  output logic                 map_wp,
  output logic                 bram_disable,
  output logic                 brom_disable,
  output logic                 irq
);

  localparam int              MAP_W = PAGE_BITS + 13;
  localparam int              TW    = $clog2(KEY_TIMEOUT + 1);
  localparam logic [TW-1:0]   T_MAX = TW'(KEY_TIMEOUT);
  localparam logic [7:0]      KEY_A = 8'hA5;
  localparam logic [7:0]      KEY_B = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_KEY1     = 2'd1,
    ST_UNLOCKED = 2'd2
  } key_state_e;

  key_state_e           state_q, state_d, key_eff;
  logic [TW-1:0]        timer_q, timer_d;
  logic [PAGE_BITS-1:0] page_q [NUM_WIN];
  logic [PAGE_BITS-1:0] page_d [NUM_WIN];
  logic [2:0]           ctrl_q, ctrl_d;
  logic [NUM_WIN-1:0]   wpmask_q, wpmask_d;
  logic [NUM_WIN-1:0]   lockmask_q, lockmask_d;
  logic                 viol_q, viol_d;
  logic                 irq_en_q, irq_en_d;
  logic                 irq_q, irq_d;

  logic                 wr_en;
  logic                 unlocked;
  logic                 viol_set;
  logic                 viol_clr;
  logic                 consume;
  logic [NUM_WIN-1:0]   din_mask;
  logic [2:0]           slot;
  logic [2:0]           win;
  logic                 in_range;
  logic [PAGE_BITS-1:0] hit_page;
  logic                 hit_wp;
  logic [7:0]           rd_data;

  // Merge one byte into a page register; hi selects bits [15:8].
  function automatic logic [PAGE_BITS-1:0] page_write(input logic [PAGE_BITS-1:0] cur,
                                                      input logic hi,
                                                      input logic [7:0] data);
    logic [15:0] ext;
    ext = 16'(cur);
    if (hi) ext[15:8] = data;
    else    ext[7:0]  = data;
    return ext[PAGE_BITS-1:0];
  endfunction

  // Extract one byte of a page register, zero-extended above PAGE_BITS.
  function automatic logic [7:0] page_byte(input logic [PAGE_BITS-1:0] cur, input logic hi);
    logic [15:0] ext;
    ext = 16'(cur);
    return hi ? ext[15:8] : ext[7:0];
  endfunction

  assign wr_en    = cs && !rw;
  assign din_mask = DI[NUM_WIN-1:0];

  // A sequence whose timer has run out behaves as IDLE in this cycle already.
  always_comb begin
    key_eff = state_q;
    if (state_q != ST_IDLE && timer_q == T_MAX) key_eff = ST_IDLE;
  end

  assign unlocked = (key_eff == ST_UNLOCKED);

  // Window decode and translation, purely from the current registers.
  assign slot     = cpu_addr[15:13];
  assign win      = slot - WIN_BASE;
  assign in_range = ({1'b0, slot} >= {1'b0, WIN_BASE}) &&
                    ({1'b0, slot} < ({1'b0, WIN_BASE} + 4'(NUM_WIN)));

  // Select page and write-protect bit of the addressed window.
  always_comb begin
    hit_page = '0;
    hit_wp   = 1'b0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (win == 3'(i)) begin
        hit_page = page_q[i];
        hit_wp   = wpmask_q[i];
      end
    end
  end

  assign map_hit  = ctrl_q[2] && in_range;
  assign map_addr = map_hit ? {hit_page, cpu_addr[12:0]} : MAP_W'(cpu_addr);
  assign map_wp   = map_hit && hit_wp && !cpu_rw;

  // Next-state: register writes, lock checks, key sequence and violation tracking.
  always_comb begin
    state_d    = key_eff;
    timer_d    = (timer_q == T_MAX) ? timer_q : timer_q + TW'(1);
    page_d     = page_q;
    ctrl_d     = ctrl_q;
    wpmask_d   = wpmask_q;
    lockmask_d = lockmask_q;
    irq_en_d   = irq_en_q;
    viol_set   = map_wp;
    viol_clr   = 1'b0;
    consume    = 1'b0;

    if (wr_en) begin
      case (AD)
        4'h8: begin
          if (unlocked) begin
            ctrl_d  = DI[2:0];
            consume = 1'b1;
          end else begin
            viol_set = 1'b1;
          end
        end
        4'h9: begin
          if (unlocked) begin
            wpmask_d = din_mask;
            consume  = 1'b1;
          end else begin
            viol_set = 1'b1;
          end
        end
        4'hA: begin
          if (unlocked) begin
            lockmask_d = din_mask;
            consume    = 1'b1;
          end else begin
            // Locking more windows is always allowed; attempting to unlock is not.
            lockmask_d = lockmask_q | din_mask;
            if ((lockmask_q & ~din_mask) != '0) viol_set = 1'b1;
          end
        end
        4'hB: begin
          case (key_eff)
            ST_IDLE: begin
              if (DI == KEY_A) begin
                state_d = ST_KEY1;
                timer_d = '0;
              end
            end
            ST_KEY1: begin
              if (DI == KEY_B) begin
                state_d = ST_UNLOCKED;
                timer_d = '0;
              end else begin
                state_d  = ST_IDLE;
                viol_set = 1'b1;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
        4'hC: begin
          irq_en_d = DI[7];
          viol_clr = DI[2];
        end
        default: ;
      endcase

      for (int i = 0; i < NUM_WIN; i++) begin
        if (AD == 4'(i) || (PAGE_BITS > 8 && AD == 4'(4 + i))) begin
          if (!lockmask_q[i] || unlocked) begin
            page_d[i] = page_write(page_q[i], AD[2], DI);
            if (lockmask_q[i]) consume = 1'b1;
          end else begin
            viol_set = 1'b1;
          end
        end
      end
    end

    if (consume) state_d = ST_IDLE;

    viol_d = viol_set | (viol_q & ~viol_clr);
    irq_d  = viol_d & irq_en_d;
  end

  // Combinational register read mux.
  always_comb begin
    rd_data = 8'h00;
    case (AD)
      4'h8:    rd_data = {5'b0, ctrl_q};
      4'h9:    rd_data = 8'(wpmask_q);
      4'hA:    rd_data = 8'(lockmask_q);
      4'hC:    rd_data = {irq_en_q, 4'b0, viol_q, state_q};
      default: ;
    endcase
    for (int i = 0; i < NUM_WIN; i++) begin
      if (AD == 4'(i)) rd_data = page_byte(page_q[i], 1'b0);
      else if (PAGE_BITS > 8 && AD == 4'(4 + i)) rd_data = page_byte(page_q[i], 1'b1);
    end
  end

  assign DO           = cs ? rd_data : 8'h00;
  assign bram_disable = ctrl_q[0];
  assign brom_disable = ctrl_q[1];
  assign irq          = irq_q;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      for (int i = 0; i < NUM_WIN; i++) page_q[i] <= PAGE_BITS'(i);
      ctrl_q     <= '0;
      wpmask_q   <= '0;
      lockmask_q <= '0;
      viol_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      for (int i = 0; i < NUM_WIN; i++) page_q[i] <= page_d[i];
      ctrl_q     <= ctrl_d;
      wpmask_q   <= wpmask_d;
      lockmask_q <= lockmask_d;
      viol_q     <= viol_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_mmu_pagemap.sv
// Bench for mmu_pagemap: directed scenarios followed by random register traffic,
// all checked against a register-level model of the page mapper.
`timescale 1ns/1ps
module tb_mmu_pagemap;

  localparam int         NUM_WIN   = 4;
  localparam int         PAGE_BITS = 8;
  localparam int         KT        = 16;
  localparam logic [2:0] WIN_BASE  = 3'd4;

  // Clock / reset and DUT signals
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  AD = '0;
  logic [7:0]  DI = '0;
  logic [7:0]  DO;
  logic        rw = 1'b1;
  logic        cs = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        cpu_rw = 1'b1;
  logic        map_hit;
  logic [20:0] map_addr;
  logic        map_wp;
  logic        bram_disable;
  logic        brom_disable;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] cur_addr = '0;
  logic        cur_rw   = 1'b1;

  always #50 clk = ~clk;

  mmu_pagemap #(
    .NUM_WIN(NUM_WIN), .PAGE_BITS(PAGE_BITS), .WIN_BASE(WIN_BASE), .KEY_TIMEOUT(KT)
  ) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .map_hit(map_hit), .map_addr(map_addr),
    .map_wp(map_wp), .bram_disable(bram_disable), .brom_disable(brom_disable), .irq(irq)
  );

  // Reference model: register contents plus the key phase and the edge at which it began.
  logic [7:0] m_page [4];
  logic [2:0] m_ctrl;
  logic [3:0] m_wpm;
  logic [3:0] m_lock;
  logic       m_viol;
  logic       m_irqen;
  int         m_phase;
  int         m_key_cyc;
  int         edge_n = 0;

  // A key phase lives for KT edges after the byte that started it.
  function automatic int eff_phase(input int n);
    if (m_phase != 0 && (n - m_key_cyc) > KT) return 0;
    return m_phase;
  endfunction

  function automatic int m_slot();
    return int'(cpu_addr[15:13]) - int'(WIN_BASE);
  endfunction

  function automatic logic m_hit();
    return m_ctrl[2] && m_slot() >= 0 && m_slot() < NUM_WIN;
  endfunction

  function automatic logic [31:0] m_addr();
    if (m_hit()) return int'(m_page[m_slot()]) * 8192 + int'(cpu_addr) % 8192;
    return 32'(cpu_addr);
  endfunction

  function automatic logic m_wp_now();
    return m_hit() && m_wpm[m_slot()] && !cpu_rw;
  endfunction

  function automatic logic [7:0] m_read(input int a);
    case (a)
      0, 1, 2, 3: return m_page[a];
      8:          return {5'b0, m_ctrl};
      9:          return {4'b0, m_wpm};
      10:         return {4'b0, m_lock};
      12:         return {m_irqen, 4'b0, m_viol, 2'(eff_phase(edge_n))};
      default:    return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    edge_n++;
    for (int i = 0; i < 4; i++) m_page[i] = 8'(i);
    m_ctrl = '0; m_wpm = '0; m_lock = '0; m_viol = 1'b0; m_irqen = 1'b0;
    m_phase = 0; m_key_cyc = 0;
  endtask

  task automatic model_edge(input bit wr, input logic [3:0] ad, input logic [7:0] di);
    int ph;
    int w;
    bit set;
    bit clr;
    edge_n++;
    ph  = eff_phase(edge_n);
    set = m_wp_now();
    clr = 1'b0;
    m_phase = ph;
    if (wr) begin
      if (int'(ad) < NUM_WIN) begin
        w = int'(ad);
        if (!m_lock[w]) m_page[w] = di;
        else if (ph == 2) begin m_page[w] = di; m_phase = 0; end
        else set = 1'b1;
      end else begin
        case (ad)
          4'h8: if (ph == 2) begin m_ctrl = di[2:0]; m_phase = 0; end else set = 1'b1;
          4'h9: if (ph == 2) begin m_wpm = di[3:0]; m_phase = 0; end else set = 1'b1;
          4'hA: begin
            if (ph == 2) begin m_lock = di[3:0]; m_phase = 0; end
            else begin
              if ((m_lock & ~di[3:0]) != 4'b0) set = 1'b1;
              m_lock = m_lock | di[3:0];
            end
          end
          4'hB: begin
            if (ph == 0) begin
              if (di == 8'hA5) begin m_phase = 1; m_key_cyc = edge_n; end
            end else if (ph == 1) begin
              if (di == 8'h5A) begin m_phase = 2; m_key_cyc = edge_n; end
              else begin m_phase = 0; set = 1'b1; end
            end else begin
              m_phase = 0;
            end
          end
          4'hC: begin m_irqen = di[7]; clr = di[2]; end
          default: ;
        endcase
      end
    end
    if (set) m_viol = 1'b1;
    else if (clr) m_viol = 1'b0;
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    cs = 1'b1; rw = 1'b1;
    for (int a = 0; a < 16; a++) begin
      AD = 4'(a);
      #1;
      chk($sformatf("rd_%0h", a), 32'(DO), 32'(m_read(a)));
    end
    cs = 1'b0;
    #1;
    chk("do_idle", 32'(DO), 32'h0);
    chk("map_hit", 32'(map_hit), 32'(m_hit()));
    chk("map_addr", 32'(map_addr), m_addr());
    chk("map_wp", 32'(map_wp), 32'(m_wp_now()));
    chk("bram_dis", 32'(bram_disable), 32'(m_ctrl[0]));
    chk("brom_dis", 32'(brom_disable), 32'(m_ctrl[1]));
    chk("irq", 32'(irq), 32'(m_viol && m_irqen));
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] ad, input logic [7:0] mask,
                        input logic [7:0] exp);
    cs = 1'b1; rw = 1'b1; AD = ad;
    #1;
    chk(tag, 32'(DO & mask), 32'(exp));
    cs = 1'b0;
  endtask

  // Driver tasks
  task automatic do_cycle(input bit wr, input logic [3:0] ad, input logic [7:0] di);
    @(negedge clk);
    cs = wr; rw = !wr; AD = ad; DI = di;
    cpu_addr = cur_addr; cpu_rw = cur_rw;
    @(posedge clk);
    model_edge(wr, ad, di);
    #1;
    cs = 1'b0; rw = 1'b1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, 4'h0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cs = 1'b0; rw = 1'b1;
    cpu_addr = cur_addr; cpu_rw = cur_rw;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    check_all();
  endtask

  task automatic unlock();
    do_cycle(1'b1, 4'hB, 8'hA5);
    do_cycle(1'b1, 4'hB, 8'h5A);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] d;

    // Reset state
    cur_addr = 16'h8123; cur_rw = 1'b1;
    do_reset();
    rd_chk("rst_page0", 4'h0, 8'hFF, 8'h00);
    rd_chk("rst_page1", 4'h1, 8'hFF, 8'h01);
    rd_chk("rst_page2", 4'h2, 8'hFF, 8'h02);
    rd_chk("rst_page3", 4'h3, 8'hFF, 8'h03);
    rd_chk("rst_ctrl", 4'h8, 8'hFF, 8'h00);
    chk("rst_hit", 32'(map_hit), 32'h0);
    chk("rst_addr", 32'(map_addr), 32'h008123);

    // Unlock, enable map, set page 2, translate $C010
    unlock();
    rd_chk("unlocked_state", 4'hC, 8'h03, 8'h02);
    do_cycle(1'b1, 4'h8, 8'h04);
    rd_chk("consumed_state", 4'hC, 8'h03, 8'h00);
    do_cycle(1'b1, 4'h2, 8'h3C);
    cur_addr = 16'hC010;
    idle(1);
    chk("xlat_hit", 32'(map_hit), 32'h1);
    chk("xlat_addr", 32'(map_addr), 32'h078010);

    // Lock window 0 then try to write it
    do_cycle(1'b1, 4'hA, 8'h01);
    do_cycle(1'b1, 4'h0, 8'h55);
    rd_chk("locked_page0", 4'h0, 8'hFF, 8'h00);
    rd_chk("locked_viol", 4'hC, 8'h04, 8'h04);
    chk("irq_before_en", 32'(irq), 32'h0);
    do_cycle(1'b1, 4'hC, 8'h80);
    chk("irq_en", 32'(irq), 32'h1);
    do_cycle(1'b1, 4'hC, 8'h84);
    rd_chk("viol_cleared", 4'hC, 8'h04, 8'h00);

    // Key timeout: second byte arrives too late
    do_cycle(1'b1, 4'hB, 8'hA5);
    idle(KT);
    do_cycle(1'b1, 4'hB, 8'h5A);
    rd_chk("timeout_state", 4'hC, 8'h07, 8'h00);
    do_cycle(1'b1, 4'h8, 8'h07);
    rd_chk("timeout_ctrl", 4'h8, 8'hFF, 8'h04);
    rd_chk("timeout_viol", 4'hC, 8'h04, 8'h04);

    // Key second byte at the last allowed cycle, then relock via $B
    do_cycle(1'b1, 4'hC, 8'h84);
    do_cycle(1'b1, 4'hB, 8'hA5);
    idle(KT - 1);
    do_cycle(1'b1, 4'hB, 8'h5A);
    rd_chk("late_unlock", 4'hC, 8'h03, 8'h02);
    do_cycle(1'b1, 4'hB, 8'h00);
    rd_chk("relock", 4'hC, 8'h07, 8'h00);

    // Write-protect window 1 ($A000)
    unlock();
    do_cycle(1'b1, 4'h9, 8'h02);
    cur_addr = 16'hA000; cur_rw = 1'b0;
    idle(1);
    chk("wp_write", 32'(map_wp), 32'h1);
    rd_chk("wp_viol", 4'hC, 8'h04, 8'h04);
    cur_rw = 1'b1;
    idle(1);
    chk("wp_read", 32'(map_wp), 32'h0);

    // Reset while unlocked
    unlock();
    do_cycle(1'b1, 4'h1, 8'h77);
    rd_chk("pre_rst_state", 4'hC, 8'h03, 8'h02);
    do_reset();
    rd_chk("post_rst_status", 4'hC, 8'hFF, 8'h00);
    rd_chk("post_rst_lock", 4'hA, 8'hFF, 8'h00);
    rd_chk("post_rst_page1", 4'h1, 8'hFF, 8'h01);
    rd_chk("post_rst_page2", 4'h2, 8'hFF, 8'h02);

    // Random register traffic and CPU addresses
    for (int t = 0; t < 400; t++) begin
      cur_addr = 16'($urandom);
      cur_rw   = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 15);
      d = 8'($urandom);
      case (r)
        0, 1, 2, 3: do_cycle(1'b1, 4'(r), d);
        4:          do_cycle(1'b1, 4'h8, d);
        5:          do_cycle(1'b1, 4'h9, d);
        6:          do_cycle(1'b1, 4'hA, d);
        7, 8:       do_cycle(1'b1, 4'hB, 8'hA5);
        9, 10:      do_cycle(1'b1, 4'hB, 8'h5A);
        11:         do_cycle(1'b1, 4'hB, d);
        12:         do_cycle(1'b1, 4'hC, d);
        13:         do_cycle(1'b1, 4'($urandom_range(0, 15)), d);
        14:         idle(1);
        default:    idle($urandom_range(1, 20));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
